// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush generation plus a
// data-memory wait tracker with a timeout watchdog.
// Optional feature macro: HAZARD_PERF_EN adds stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic        ID_use_rs1,
  input  logic        ID_use_rs2,
  input  logic        ID_EX_memread,
  input  logic [4:0]  ID_EX_rd,
  input  logic        EX_take,
  input  logic        EX_MEM_memreq,
  input  logic        dmem_ready,
  output logic        IF_stall,
  output logic        ID_stall,
  output logic        EX_stall,
  output logic        MEM_stall,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   wait_cnt, wait_cnt_nx;
  logic            mem_timeout_nx;
  logic            memwait;
  logic            loaduse;

  // Hazard detection terms
  always_comb begin
    memwait = EX_MEM_memreq & ~dmem_ready;
    loaduse = ID_EX_memread & (ID_EX_rd != 5'd0) &
              ((ID_use_rs1 & (ID_rs1 == ID_EX_rd)) |
               (ID_use_rs2 & (ID_rs2 == ID_EX_rd)));
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      mem_timeout <= mem_timeout_nx;
    end
  end

  // Next-state logic for the memory wait tracker
  always_comb begin
    state_nx       = state;
    wait_cnt_nx    = wait_cnt;
    mem_timeout_nx = mem_timeout;
    unique case (state)
      S_RUN: begin
        if (memwait) begin
          state_nx    = S_WAIT;
          wait_cnt_nx = CW'(1);
        end
      end
      S_WAIT: begin
        if (!memwait) begin
          state_nx    = S_RUN;
          wait_cnt_nx = '0;
        end else if (wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
          state_nx       = S_HALT;
          mem_timeout_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx    = S_RUN;
        wait_cnt_nx = '0;
      end
    endcase
  end

  // Prioritised pipeline controls; all forced low while in reset
  always_comb begin
    IF_stall     = 1'b0;
    ID_stall     = 1'b0;
    EX_stall     = 1'b0;
    MEM_stall    = 1'b0;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (reset_n) begin
      if ((state == S_HALT) || memwait) begin
        IF_stall  = 1'b1;
        ID_stall  = 1'b1;
        EX_stall  = 1'b1;
        MEM_stall = 1'b1;
      end else if (EX_take) begin
        // Dependent instruction in ID is discarded, so load-use is moot
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end else if (loaduse) begin
        IF_stall     = 1'b1;
        ID_stall     = 1'b1;
        ID_EX_bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating counters of stall and flush cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (IF_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (IF_ID_flush && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned MT = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] ID_rs1, ID_rs2, ID_EX_rd;
  logic       ID_use_rs1, ID_use_rs2, ID_EX_memread, EX_take;
  logic       EX_MEM_memreq, dmem_ready;
  logic       IF_stall, ID_stall, EX_stall, MEM_stall;
  logic       ID_EX_bubble, IF_ID_flush, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset_n(reset_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_EX_memread(ID_EX_memread), .ID_EX_rd(ID_EX_rd),
    .EX_take(EX_take), .EX_MEM_memreq(EX_MEM_memreq), .dmem_ready(dmem_ready),
    .IF_stall(IF_stall), .ID_stall(ID_stall), .EX_stall(EX_stall),
    .MEM_stall(MEM_stall), .ID_EX_bubble(ID_EX_bubble),
    .IF_ID_flush(IF_ID_flush), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: length of current not-ready run, halted flag
  int          run_len;
  bit          halted;
  int unsigned m_stalls, m_flushes;

  // Observed outputs in order {IF, ID, EX, MEM, bubble, flush, timeout}
  logic [6:0] got, exp;
  assign got = {IF_stall, ID_stall, EX_stall, MEM_stall,
                ID_EX_bubble, IF_ID_flush, mem_timeout};

  function automatic logic [6:0] model_out();
    logic [6:0] r;
    bit mw, lu;
    r  = '0;
    mw = EX_MEM_memreq && !dmem_ready;
    lu = ID_EX_memread && (ID_EX_rd != 0) &&
         ((ID_use_rs1 && ID_rs1 == ID_EX_rd) || (ID_use_rs2 && ID_rs2 == ID_EX_rd));
    if (!reset_n) return r;
    r[0] = halted;
    if (halted || mw)  r[6:3] = 4'b1111;
    else if (EX_take)  r[2:1] = 2'b11;
    else if (lu)       begin r[6:5] = 2'b11; r[2] = 1'b1; end
    return r;
  endfunction

  task automatic model_reset();
    halted = 0; run_len = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Advance one clock edge and update the model with the sampled inputs
  task automatic tick();
    logic [6:0] o;
    @(posedge clk);
    o = model_out();
    if (reset_n) begin
      if (o[6] && m_stalls  != 32'hFFFF_FFFF) m_stalls++;
      if (o[1] && m_flushes != 32'hFFFF_FFFF) m_flushes++;
      if (!halted) begin
        if (EX_MEM_memreq && !dmem_ready) begin
          run_len++;
          if (run_len >= MT) halted = 1;
        end else run_len = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    ID_EX_memread = 0; ID_EX_rd = 0; EX_take = 0;
    EX_MEM_memreq = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    model_reset();
    EX_MEM_memreq = 1; EX_take = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL reset_hold got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
    reset_n = 1;
    idle();
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL reset_release got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
  endtask

  task automatic test_loaduse();
    idle();
    ID_EX_memread = 1; ID_EX_rd = 5; ID_rs1 = 5; ID_use_rs1 = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b1100100) begin
      $display("FAIL loaduse got=%b exp=%b", got, 7'b1100100); bad++;
    end
    tick();
    ID_EX_memread = 0;
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL loaduse_after got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
    // rs2 match
    idle();
    ID_EX_memread = 1; ID_EX_rd = 9; ID_rs2 = 9; ID_use_rs2 = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b1100100) begin
      $display("FAIL loaduse_rs2 got=%b exp=%b", got, 7'b1100100); bad++;
    end
    tick();
  endtask

  task automatic test_x0_unused();
    idle();
    ID_EX_memread = 1; ID_EX_rd = 0; ID_rs1 = 0; ID_use_rs1 = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL x0_dest got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
    idle();
    ID_EX_memread = 1; ID_EX_rd = 7; ID_rs2 = 7; ID_use_rs2 = 0;
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL unused_rs2 got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
  endtask

  task automatic test_memwait();
    idle();
    EX_MEM_memreq = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (got !== 7'b1111000) begin
        $display("FAIL memwait_%0d got=%b exp=%b", i, got, 7'b1111000); bad++;
      end
      tick();
    end
    dmem_ready = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL memwait_ready got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
    idle();
  endtask

  task automatic test_branch();
    idle();
    EX_take = 1; ID_EX_memread = 1; ID_EX_rd = 3; ID_rs1 = 3; ID_use_rs1 = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b0000110) begin
      $display("FAIL take_over_loaduse got=%b exp=%b", got, 7'b0000110); bad++;
    end
    tick();
    idle();
    EX_take = 1; EX_MEM_memreq = 1; dmem_ready = 0;
    @(negedge clk);
    total++;
    if (got !== 7'b1111000) begin
      $display("FAIL take_in_memwait got=%b exp=%b", got, 7'b1111000); bad++;
    end
    tick();
    dmem_ready = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b0000110) begin
      $display("FAIL take_after_ready got=%b exp=%b", got, 7'b0000110); bad++;
    end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    // Ready on the final-count cycle beats the timeout
    idle();
    EX_MEM_memreq = 1;
    for (int i = 0; i < MT - 1; i++) tick();
    dmem_ready = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL ready_at_final got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
    // New request right after ready counts again from 1
    dmem_ready = 0;
    for (int i = 0; i < MT - 1; i++) tick();
    dmem_ready = 1;
    tick();
    idle();
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL restart_count got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ID_rs1        = 5'($urandom_range(0, 3));
      ID_rs2        = 5'($urandom_range(0, 3));
      ID_use_rs1    = 1'($urandom);
      ID_use_rs2    = 1'($urandom);
      ID_EX_memread = 1'($urandom);
      ID_EX_rd      = 5'($urandom_range(0, 3));
      EX_take       = ($urandom_range(0, 5) == 0);
      EX_MEM_memreq = ($urandom_range(0, 3) == 0);
      dmem_ready    = 1'($urandom);
      @(negedge clk);
      exp = model_out();
      total++;
      if (got !== exp) begin
        $display("FAIL random_%0d got=%b exp=%b", n, got, exp); bad++;
      end
      tick();
    end
    idle();
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== m_stalls || perf_flush_cnt !== m_flushes) begin
      $display("FAIL perf_counts got=%0d/%0d exp=%0d/%0d",
               perf_stall_cnt, perf_flush_cnt, m_stalls, m_flushes); bad++;
    end
`endif
  endtask

  task automatic test_watchdog();
    // Asynchronous reset mid-cycle, no clock edge needed
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    model_reset();
    total++;
    if (got !== 7'b0) begin
      $display("FAIL async_reset_pre got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
    reset_n = 1;
    idle();
    EX_MEM_memreq = 1;
    for (int i = 0; i < MT; i++) begin
      @(negedge clk);
      exp = model_out();
      total++;
      if (got !== exp || exp !== 7'b1111000) begin
        $display("FAIL wd_wait_%0d got=%b exp=%b", i, got, 7'b1111000); bad++;
      end
      tick();
    end
    dmem_ready = 1;
    @(negedge clk);
    total++;
    if (got !== 7'b1111001) begin
      $display("FAIL wd_halt got=%b exp=%b", got, 7'b1111001); bad++;
    end
    tick();
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    total++;
    if (perf_stall_cnt !== MT + 1) begin
      $display("FAIL perf_wd got=%0d exp=%0d", perf_stall_cnt, MT + 1); bad++;
    end
`endif
    @(negedge clk); #2;
    reset_n = 0;
    #1;
    model_reset();
    total++;
    if (got !== 7'b0) begin
      $display("FAIL async_reset_halt got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
    reset_n = 1;
    idle();
    @(negedge clk);
    total++;
    if (got !== 7'b0) begin
      $display("FAIL after_halt_reset got=%b exp=%b", got, 7'b0); bad++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_x0_unused();
    test_memwait();
    test_branch();
    test_back_to_back();
    test_random();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
